// File: rtl/run_sequencer.sv
// Run controller for the 9-bit core: turns a Start/Ack handshake into a
// reset / PC-load / run sequence, with halt detection, cycle count and watchdog.
module run_sequencer #(
  parameter int             PW          = 10,
  parameter int             IW          = 9,
  parameter logic [3:0]     HALT_OP     = 4'b1101,
  parameter int             INIT_CYCLES = 2,
  parameter logic [15:0]    MAX_CYCLES  = 16'hFFFF,
  parameter logic [PW-1:0]  ENTRY0      = PW'(0),
  parameter logic [PW-1:0]  ENTRY1      = PW'(256),
  parameter logic [PW-1:0]  ENTRY2      = PW'(512),
  parameter logic [PW-1:0]  ENTRY3      = PW'(768)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic [IW-1:0] Instruction,
  output logic          CoreRst,
  output logic          PCLoad,
  output logic [PW-1:0] PCLoadAddr,
  output logic          RunEn,
  output logic          Ack,
  output logic          Timeout,
  output logic [15:0]   CycleCt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4,
    TMO  = 3'd5
  } state_t;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t         state_q, state_d;
  logic           start_q;
  logic [1:0]     sel_q, sel_d;
  logic [3:0]     init_ct_q, init_ct_d;
  logic [15:0]    cycle_ct_q, cycle_ct_d;
  logic [PW-1:0]  addr_q, addr_d;
  logic           core_rst_q, core_rst_d;
  logic           pc_load_q, pc_load_d;
  logic           run_en_q, run_en_d;
  logic           ack_q, ack_d;
  logic           timeout_q, timeout_d;
  logic           start_edge;
  logic           is_halt;
  logic           unused_instr_bits;

  function automatic logic [PW-1:0] entry_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    entry_addr = ENTRY0;
      2'd1:    entry_addr = ENTRY1;
      2'd2:    entry_addr = ENTRY2;
      default: entry_addr = ENTRY3;
    endcase
  endfunction

  assign start_edge        = Start & ~start_q;
  assign is_halt           = (Instruction[IW-1 -: 4] == HALT_OP);
  assign unused_instr_bits = ^Instruction[IW-5:0];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    init_ct_d  = init_ct_q;
    cycle_ct_d = cycle_ct_q;
    addr_d     = addr_q;
    // A fresh Start edge restarts the sequence from any state, even mid-run.
    if (start_edge) begin
      state_d    = INIT;
      sel_d      = ProgSel;
      init_ct_d  = 4'd0;
      cycle_ct_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        INIT: begin
          init_ct_d = init_ct_q + 4'd1;
          if (init_ct_q == INIT_LAST) state_d = LOAD;
        end
        LOAD: state_d = RUN;
        RUN: begin
          if (is_halt)                        state_d    = DONE;
          else if (cycle_ct_q == MAX_CYCLES)  state_d    = TMO;
          else                                cycle_ct_d = cycle_ct_q + 16'd1;
        end
        DONE:    state_d = DONE;
        TMO:     state_d = TMO;
        default: state_d = IDLE;
      endcase
    end
    if (state_d == LOAD) addr_d = entry_addr(sel_q);
    // Outputs are registered from the next state so they are glitch-free Moore outputs.
    core_rst_d = (state_d == IDLE) || (state_d == INIT);
    pc_load_d  = (state_d == LOAD);
    run_en_d   = (state_d == RUN);
    ack_d      = (state_d == DONE) || (state_d == TMO);
    timeout_d  = (state_d == TMO);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      sel_q      <= 2'd0;
      init_ct_q  <= 4'd0;
      cycle_ct_q <= 16'd0;
      addr_q     <= ENTRY0;
      core_rst_q <= 1'b1;
      pc_load_q  <= 1'b0;
      run_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= Start;
      sel_q      <= sel_d;
      init_ct_q  <= init_ct_d;
      cycle_ct_q <= cycle_ct_d;
      addr_q     <= addr_d;
      core_rst_q <= core_rst_d;
      pc_load_q  <= pc_load_d;
      run_en_q   <= run_en_d;
      ack_q      <= ack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign CoreRst    = core_rst_q;
  assign PCLoad     = pc_load_q;
  assign PCLoadAddr = addr_q;
  assign RunEn      = run_en_q;
  assign Ack        = ack_q;
  assign Timeout    = timeout_q;
  assign CycleCt    = cycle_ct_q;

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Top-level run controller for the 9-bit single-cycle core.
- Turns the external Start/Ack handshake into a fixed core bring-up sequence: hold core reset, load the PC with the selected program's entry address, then let the core run.
- Detects the halt opcode, counts executed cycles, and provides a watchdog timeout.
- Sits between the testbench/top-level ports and the InstFetch/RegFile/DataMem reset and enable inputs.

Parameters:
- PW, 10, program-counter width.
- IW, 9, instruction width.
- HALT_OP, 4'b1101, opcode (Instruction[IW-1:IW-4]) that ends a program.
- INIT_CYCLES, 2, cycles CoreRst is held after a start; legal range 1..15.
- MAX_CYCLES, 16'hFFFF, watchdog limit on counted RUN cycles.
- ENTRY0..ENTRY3, 10'd0 / 10'd256 / 10'd512 / 10'd768, PC entry address for program 0..3.

Ports:
- Clk, input, 1, clock; all state updates on posedge.
- Reset, input, 1, asynchronous active-high reset.
- Start, input, 1, start request; acted on at its rising edge.
- ProgSel, input, 2, program index; sampled on the Start rising edge.
- Instruction, input, IW, current instruction from InstROM.
- CoreRst, output, 1, reset to PC, register file and data memory.
- PCLoad, output, 1, one-cycle absolute PC load strobe.
- PCLoadAddr, output, PW, entry address driven with PCLoad.
- RunEn, output, 1, PC advance and register/memory write enable.
- Ack, output, 1, program finished (halt or timeout).
- Timeout, output, 1, program ended by the watchdog.
- CycleCt, output, 16, number of RUN cycles executed.

Behaviour:
- Reset (async):
  - state = IDLE, StartQ = 0, SelQ = 0, init counter = 0, CycleCt = 0.
  - Ack = 0, Timeout = 0, CoreRst = 1, PCLoad = 0, RunEn = 0, PCLoadAddr = ENTRY0.
- Start edge detection:
  - StartQ is Start registered.
  - StartEdge = Start & ~StartQ.
  - Holding Start high produces exactly one edge.
- StartEdge in any state, including mid-RUN:
  - next state INIT.
  - SelQ <= ProgSel, init counter <= 0, CycleCt <= 0, Ack/Timeout <= 0.
  - StartEdge has priority over every other transition.
- States and registered (Moore) outputs:
  - IDLE: CoreRst=1, RunEn=0, Ack=0. Waits for StartEdge.
  - INIT: CoreRst=1. Counter increments each cycle. When counter == INIT_CYCLES-1, go to LOAD. INIT lasts exactly INIT_CYCLES cycles.
  - LOAD: CoreRst=0, PCLoad=1, PCLoadAddr = ENTRY[SelQ], RunEn=0. Lasts one cycle, then RUN.
  - RUN: RunEn=1, PCLoadAddr holds ENTRY[SelQ]. Evaluated in this order each cycle:
    1. If Instruction[IW-1:IW-4] == HALT_OP, go to DONE. The halt cycle is not counted.
    2. Else if CycleCt == MAX_CYCLES, go to TIMEOUT.
    3. Else CycleCt <= CycleCt + 1.
  - DONE: RunEn=0, CoreRst=0, Ack=1, Timeout=0. CycleCt frozen. Stays until StartEdge.
  - TIMEOUT: RunEn=0, CoreRst=0, Ack=1, Timeout=1. CycleCt frozen at MAX_CYCLES. Stays until StartEdge.
- Latency:
  - StartEdge in cycle t puts INIT in cycle t+1.
  - LOAD at t+1+INIT_CYCLES.
  - First RUN cycle at t+2+INIT_CYCLES.
  - Ack rises the cycle after the halt instruction is presented in RUN.
- Ack and Timeout are only ever high in DONE/TIMEOUT. Both fall in the cycle the machine enters INIT.
- CycleCt never wraps: the increment is blocked at MAX_CYCLES.
- Reset asserted mid-RUN: returns to IDLE immediately (async) with CoreRst=1. No Ack.
- Illegal state encodings recover to IDLE on the next clock.

Test Plan:
- Reset release with Start=0 for 5 cycles -> state IDLE, CoreRst=1, Ack=0, RunEn=0, CycleCt=0.
- Start 0->1 with ProgSel=2, INIT_CYCLES=2, halt presented on the 7th RUN cycle -> CoreRst high 2 cycles; PCLoad=1 one cycle with PCLoadAddr=512; RunEn high 7 cycles; Ack=1, Timeout=0, CycleCt=6 and held.
- MAX_CYCLES=10, no halt ever -> Ack=1 and Timeout=1 after RUN cycle 11; CycleCt=10 and stays 10 for 20 further cycles.
- New Start edge 4 cycles into RUN with ProgSel=1 -> next cycle INIT, CycleCt=0, Ack=0; PCLoadAddr=256 at LOAD.
- Start held high 50 cycles through a complete program -> exactly one INIT/LOAD sequence; Ack stays 1 after halt until Start falls and rises again.
- Reset pulse asserted between clock edges during RUN -> CoreRst=1 and RunEn=0 before the next posedge; Ack=0; a following Start edge runs normally.
